spi_reg_ctrl: RTL

Command/register controller behind the SPI slave. It parses the byte stream (`spi_data_out`/`spi_data_stb`) into a command byte and then a data phase. It drives a 128-entry register bus with single-cycle write pulses and 1-cycle-latency reads. It keeps `spi_data_in` loaded with the next byte the slave will shift out: a status byte at transaction start, then register read data.

---
 rtl/spi_ctrl_pkg.sv | 16 +
 rtl/spi_reg_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI register controller.
// Imported by spi_reg_ctrl.
package spi_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        FETCH,
        READ,
        WDATA
    } state_e;

    localparam int CMD_RW_BIT = 7;
    localparam int ADDR_W     = 7;

endpackage

// File: rtl/spi_reg_ctrl.sv
// Command/register controller behind the SPI slave: parses command
// and data bytes, drives the register bus, feeds the transmit byte.
module spi_reg_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter logic [6:0] STATUS_ID = 7'h5A,
    parameter logic [6:0] RO_BASE   = 7'h60
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_tsx_start,
    input  logic [7:0]        spi_data_out,
    input  logic              spi_data_stb,
    output logic [7:0]        spi_data_in,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    input  logic              err_clr,
    output logic              wr_err,
    output logic [7:0]        last_cmd
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        spi_din_q, spi_din_d;
    logic [7:0]        last_cmd_q, last_cmd_d;
    logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
    logic [7:0]        reg_wdata_q, reg_wdata_d;
    logic              wr_err_q, wr_err_d;
    logic              we_d, re_d, err_set;

    // Next-state, bus strobes and transmit byte; strobes are issued in
    // the stb cycle so read data lands one cycle later, during FETCH.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        spi_din_d   = spi_din_q;
        last_cmd_d  = last_cmd_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        we_d        = 1'b0;
        re_d        = 1'b0;
        err_set     = 1'b0;
        if (spi_tsx_start) begin
            state_d   = CMD;
            spi_din_d = {wr_err_q, STATUS_ID};
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                CMD: begin
                    if (spi_data_stb) begin
                        last_cmd_d = spi_data_out;
                        addr_d     = spi_data_out[ADDR_W-1:0];
                        if (spi_data_out[CMD_RW_BIT]) begin
                            re_d       = 1'b1;
                            reg_addr_d = spi_data_out[ADDR_W-1:0];
                            state_d    = FETCH;
                        end else begin
                            state_d = WDATA;
                        end
                    end
                end
                FETCH: begin
                    spi_din_d = reg_rdata;
                    addr_d    = addr_q + 7'd1;
                    state_d   = READ;
                end
                READ: begin
                    if (spi_data_stb) begin
                        re_d       = 1'b1;
                        reg_addr_d = addr_q;
                        state_d    = FETCH;
                    end
                end
                WDATA: begin
                    if (spi_data_stb) begin
                        if (addr_q < RO_BASE) begin
                            we_d        = 1'b1;
                            reg_addr_d  = addr_q;
                            reg_wdata_d = spi_data_out;
                        end else begin
                            err_set = 1'b1;
                        end
                        addr_d = addr_q + 7'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        if (err_set) begin
            wr_err_d = 1'b1;
        end else if (err_clr) begin
            wr_err_d = 1'b0;
        end else begin
            wr_err_d = wr_err_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            spi_din_q   <= {1'b0, STATUS_ID};
            last_cmd_q  <= '0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            wr_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            spi_din_q   <= spi_din_d;
            last_cmd_q  <= last_cmd_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            wr_err_q    <= wr_err_d;
        end
    end

    // Bus signals are live in the stb cycle and hold their last value
    // otherwise; reset forces them quiet.
    always_comb begin
        reg_we    = we_d & ~rst;
        reg_re    = re_d & ~rst;
        reg_addr  = rst ? '0 : reg_addr_d;
        reg_wdata = rst ? '0 : reg_wdata_d;
    end

    assign spi_data_in = spi_din_q;
    assign wr_err      = wr_err_q;
    assign last_cmd    = last_cmd_q;

endmodule
